// File: rtl/input_debouncer.sv
// Debounces a raw single-bit input into a clean, clock-aligned level with rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to insert a two-flop synchronizer ahead of the stability counter.
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       clr,
    output logic       dout,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] edge_cnt
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [7:0]       edge_q, edge_d;

`ifdef DEBOUNCE_SYNC_EN
    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    assign s = s2_q;
`else
    logic s1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
        end else begin
            s1_q <= din;
        end
    end

    assign s = s1_q;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        edge_d = edge_q;

        if (s != dout_q) begin
            if (cnt_q == LastCount) begin
                dout_d = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            // Sample fell back to the accepted level: drop the candidate.
            cnt_d = '0;
        end

        if (clr) begin
            edge_d = '0;
        end else if (rise_d || fall_d) begin
            edge_d = edge_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            edge_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            edge_q <= edge_d;
        end
    end

    assign dout     = dout_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign busy     = (cnt_q != '0);
    assign edge_cnt = edge_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer (STABLE_CYCLES = 4).
module tb_input_debouncer;

    localparam int unsigned Stable = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int Lat = Stable + 2;
`else
    localparam int Lat = Stable + 1;
`endif

    logic       clk;
    logic       reset;
    logic       din;
    logic       clr;
    logic       dout;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] edge_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic exp_d;
    int   exp_ec;

    input_debouncer #(
        .STABLE_CYCLES(Stable),
        .CNT_W        (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .clr     (clr),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy),
        .edge_cnt(edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic d, input logic r, input logic f,
                              input logic b, input int unsigned ec);
        check({tag, ".dout"}, 32'(dout), 32'(d));
        check({tag, ".rise"}, 32'(rise), 32'(r));
        check({tag, ".fall"}, 32'(fall), 32'(f));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".edge_cnt"}, 32'(edge_cnt), ec);
    endtask

    // Advance n rising edges, then settle just past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) check("rise_fall_excl", 32'(rise & fall), 0);
    end

    initial begin
        reset = 1'b0;
        din   = 1'b0;
        clr   = 1'b0;
        #1;
        check_outs("rst0", 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            din = ~din;
            step(1);
            check_outs("rst_hold", 0, 0, 0, 0, 0);
        end
        din = 1'b0;
        step(1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_outs("rst_rel", 0, 0, 0, 0, 0);
        end

        // Clean press
        din = 1'b1;
        step(Lat - 1);
        check_outs("press_pre", 0, 0, 0, 1, 0);
        step(1);
        check_outs("press", 1, 1, 0, 0, 1);
        step(1);
        check_outs("press_post", 1, 0, 0, 0, 1);

        // Clean release
        din = 1'b0;
        step(Lat - 1);
        check_outs("rel_pre", 1, 0, 0, 1, 1);
        step(1);
        check_outs("rel", 0, 0, 1, 0, 2);
        step(1);
        check_outs("rel_post", 0, 0, 0, 0, 2);

        // Bounce: three cycles high, one low, then held high
        din = 1'b1;
        step(3);
        din = 1'b0;
        step(1);
        din = 1'b1;
        check_outs("bnc_mid", 0, 0, 0, 1, 2);
        step(Lat - 4);
        check_outs("bnc_drop", 0, 0, 0, 0, 2);
        step(3);
        check_outs("bnc_requal", 0, 0, 0, 1, 2);
        step(1);
        check_outs("bnc_accept", 1, 1, 0, 0, 3);
        step(1);
        din = 1'b0;
        step(Lat + 1);
        check_outs("bnc_release", 0, 0, 0, 0, 4);

        // Wrap edge_cnt through 255 -> 0
        exp_d  = 1'b0;
        exp_ec = 4;
        for (int k = 0; k < 251; k++) begin
            din = ~din;
            step(Lat + 1);
            exp_d  = ~exp_d;
            exp_ec = (exp_ec + 1) % 256;
            check("wrap.dout", 32'(dout), 32'(exp_d));
        end
        check("wrap.255", 32'(edge_cnt), 255);
        din = ~din;
        step(Lat + 1);
        exp_d = ~exp_d;
        check("wrap.0", 32'(edge_cnt), 0);

        // Plain clr
        din = ~din;
        step(Lat + 1);
        exp_d = ~exp_d;
        check("clr_pre", 32'(edge_cnt), 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr", 32'(edge_cnt), 0);

        // clr on the same edge as an accepted transition
        din = ~din;
        step(Lat - 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        exp_d = ~exp_d;
        check("clr_simul.dout", 32'(dout), 32'(exp_d));
        check("clr_simul.pulse", 32'(rise | fall), 1);
        check("clr_simul.cnt", 32'(edge_cnt), 0);
        step(1);
        check("clr_simul.after", 32'(edge_cnt), 0);

        // Two transitions to leave dout=0 with a nonzero count
        din = 1'b1;
        step(Lat + 1);
        din = 1'b0;
        step(Lat + 1);
        check_outs("pre_mq", 0, 0, 0, 0, 2);

        // Reset in the middle of qualification
        din = 1'b1;
        step(Lat - 2);
        check_outs("mq_busy", 0, 0, 0, 1, 2);
        #2;
        reset = 1'b0;
        #1;
        check_outs("mq_rst", 0, 0, 0, 0, 0);
        step(2);
        check_outs("mq_hold", 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(Lat - 1);
        check_outs("mq_pre", 0, 0, 0, 1, 0);
        step(1);
        check_outs("mq_accept", 1, 1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, asynchronous, possibly bouncing single-bit input (push-button or switch) into a clean, clock-aligned level that drives the D input of the downstream asynchronous-reset flip-flop stage. It provides an optional two-flop synchronizer, a stability counter that accepts a new level only after it has held for a programmable number of cycles, and one-cycle rise/fall pulses. It also keeps a wrap-around count of accepted transitions for bring-up and debug.

## Interface
- STABLE_CYCLES, 4: consecutive sampled cycles a new level must hold before acceptance; legal range 1..2^CNT_W.
- CNT_W, 8: width of the stability counter.
- clk  input  1  rising-edge clock; sole clock of the block.
- reset  input  1  asynchronous, active-low reset. Assertion clears all state immediately. Deassertion is synchronous to clk at the system level.
- din  input  1  raw input; may change at any time, including mid-cycle.
- clr  input  1  synchronous clear of edge_cnt, sampled on the clk rising edge.
- dout  output  1  debounced level; feeds the downstream D flip-flop.
- rise  output  1  one-cycle pulse when dout goes 0->1.
- fall  output  1  one-cycle pulse when dout goes 1->0.
- busy  output  1  high while a candidate level is being qualified (stability counter non-zero).
- edge_cnt  output  8  number of accepted dout transitions, modulo 256.

## Operation
- Sampled value s:
  - With the synchronizer: s is the second synchronizer stage (s1 -> s2).
  - Without it: s is a single capture register s1.
- States:
  - IDLE: s == dout and counter == 0.
  - QUALIFY: counter != 0.
- On each rising edge, when s != dout:
  - If counter == STABLE_CYCLES-1: dout <= s, counter <= 0, and rise or fall is set to 1 according to the new level.
  - Otherwise counter <= counter+1.
- On each rising edge, when s == dout: counter <= 0 (glitch rejected, return to IDLE); rise and fall are 0.
- rise and fall are registered. Both are never high in the same cycle, and each is high for exactly one cycle per accepted transition.
- busy = (counter != 0), combinational from the counter register.
- edge_cnt:
  - Increments on every cycle in which rise or fall is set.
  - Wraps 255 -> 0.
  - clr forces it to 0. clr takes priority over a simultaneous increment, so the result is 0.
- STABLE_CYCLES == 1: a mismatch is accepted on the first edge it is observed; busy never asserts.

## Timing
- Reset values while reset is low: dout=0, rise=0, fall=0, busy=0, edge_cnt=0, counter=0, all synchronizer/capture flops 0.
- Reset asserted mid-qualification aborts the qualification. After release the block starts from IDLE with dout=0.
- Latency: count the rising edge that first captures the new din into s1 as edge 1.
  - With the synchronizer: dout, and rise or fall, update on edge STABLE_CYCLES+2.
  - Without it: they update on edge STABLE_CYCLES+1.
- A din pulse is discarded if its sampled width is shorter than STABLE_CYCLES cycles. dout does not move and edge_cnt is unchanged.
- If din returns to the old level during QUALIFY, the counter restarts from 0 on the first edge where s == dout again.
- No handshake. Downstream consumers sample dout, rise and fall on the same clk.

## Configuration
- DEBOUNCE_SYNC_EN defined: a two-flop synchronizer precedes the stability counter. This is the required setting whenever din is truly asynchronous to clk.
- DEBOUNCE_SYNC_EN undefined: a single capture register is used. Latency is one cycle shorter, and din must already be synchronous to clk.

## Test plan
- Reset: hold reset=0 with din=1 toggling -> dout=0, rise=fall=busy=0, edge_cnt=0 throughout. Release reset with din=0 -> all outputs stay 0.
- Clean press: STABLE_CYCLES=4, synchronizer on, din 0->1 held before edge 1 -> dout=1 and rise=1 on edge 6 only, edge_cnt=1. Without the synchronizer -> update on edge 5.
- Bounce: din=1 for 3 cycles, 0 for 1 cycle, then 1 held -> no update during the bounce, busy drops to 0 for one cycle. dout rises 6 edges after the final 0->1 capture; edge_cnt=1.
- Release and fall: from dout=1, din 1->0 held -> fall pulses once, dout=0, edge_cnt=2. rise and fall are never high together.
- Counter wrap and clr: drive 256 accepted transitions -> edge_cnt returns to 0. Assert clr on the same edge as an accepted transition -> edge_cnt=0.
- Reset mid-qualify: assert reset while busy=1 with counter=2 -> outputs clear immediately. After release with din=1 held -> full STABLE_CYCLES qualification occurs before dout=1.
